// File: rtl/mdu_seq_if.sv
// Handshake bundle between EX and the HI/LO multiply/divide sequencer.
// EX drives the request side (master); the sequencer drives stall, strobe and results (slave).
interface mdu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             op_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall_ex;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             div_zero;

    modport master (
        output flush, op_valid, op, src_a, src_b,
        input  stall_ex, hilo_we, hi_out, lo_out, busy, div_zero
    );

    modport slave (
        input  flush, op_valid, op, src_a, src_b,
        output stall_ex, hilo_we, hi_out, lo_out, busy, div_zero
    );
endinterface

// File: rtl/mdu_seq.sv
// HI/LO multiply/divide sequencer: one-cycle multiply, WIDTH-step restoring divide,
// with an EX stall request held until the HI/LO write strobe.
module mdu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    mdu_seq_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // a_q holds the multiplicand, or the dividend shifting out as quotient bits shift in
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic             is_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, trial;
    logic             take;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign is_signed = ~bus.op[0];
    assign a_mag = (is_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign b_mag = (is_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    // Borrow out of the (WIDTH+1)-bit trial subtract says whether the divisor fits
    assign rem_sh = {rem_q, a_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, b_q};
    assign take   = ~trial[WIDTH];
    assign rem_nx = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {a_q[WIDTH-2:0], take};

    assign prod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign prod_s = neg_quo_q ? -prod : prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        if (bus.flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.op_valid) begin
                        a_d       = a_mag;
                        b_d       = b_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        dz_d      = 1'b0;
                        neg_quo_d = is_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                        neg_rem_d = is_signed & bus.src_a[WIDTH-1];
                        if (!bus.op[1]) begin
                            state_d = StMul;
                        end else if (bus.src_b == '0) begin
                            state_d = StDone;
                            hi_d    = bus.src_a;
                            lo_d    = '1;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = StDiv;
                        end
                    end
                end
                StMul: begin
                    hi_d    = prod_s[2*WIDTH-1:WIDTH];
                    lo_d    = prod_s[WIDTH-1:0];
                    state_d = StDone;
                end
                StDiv: begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        hi_d    = neg_rem_q ? -rem_nx : rem_nx;
                        lo_d    = neg_quo_q ? -quo_nx : quo_nx;
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.stall_ex = ~bus.flush & (((state_q == StIdle) & bus.op_valid)
                                     | (state_q == StMul) | (state_q == StDiv));
        bus.hilo_we  = ~bus.flush & (state_q == StDone);
        bus.busy     = (state_q != StIdle);
        bus.hi_out   = hi_q;
        bus.lo_out   = lo_q;
        bus.div_zero = dz_q;
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, hand-built flush/reset sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_hi, last_lo;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: results straight from 64-bit integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0;
        if (!op[1]) begin
            if (!op[0]) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            hi  = p[63:32];
            lo  = p[31:0];
            lat = 2;
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dz  = 1'b1;
            lat = 1;
        end else begin
            if (!op[0]) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q   = sa / sb;
            r   = sa % sb;
            hi  = r[31:0];
            lo  = q[31:0];
            lat = 33;
        end
    endtask

    // Presents an op (EX holds it through DONE) and checks stall length and the DONE cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int elat, input string name);
        int stalls;
        bit seen;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.hilo_we) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall_ex) stalls++;
            @(negedge clk);
            #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no hilo_we within 100 cycles, stall count %0d", name, stalls);
        end else begin
            chk({name, " latency"}, 32'(stalls), 32'(elat));
            chk({name, " stall_done"}, 32'(bus.stall_ex), 32'd0);
            chk({name, " busy_done"}, 32'(bus.busy), 32'd1);
            chk({name, " hi"}, bus.hi_out, ehi);
            chk({name, " lo"}, bus.lo_out, elo);
            chk({name, " div_zero"}, 32'(bus.div_zero), 32'(edz));
        end
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, ehi, elo;
        logic        edz;
        int          elat, extra;

        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 2'b00;
        bus.src_a    = '0;
        bus.src_b    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset stall_ex", 32'(bus.stall_ex), 32'd0);
        chk("reset hilo_we", 32'(bus.hilo_we), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset hi", bus.hi_out, 32'd0);
        chk("reset lo", bus.lo_out, 32'd0);
        chk("reset div_zero", 32'(bus.div_zero), 32'd0);
        rst = 1'b0;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2};
        vecs[1] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33};
        vecs[4] = '{2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 2};
        vecs[6] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[7] = '{2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[8] = '{2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2};
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                  vecs[i].lat, $sformatf("vec%0d", i));
            if (i % 2 == 1) go_idle();
        end
        go_idle();

        // Flush at divide iteration 10: no strobe, HI/LO untouched, then a clean MULTU.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = 2'b10;
        bus.src_a    = 32'd1000;
        bus.src_b    = 32'd3;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_div stall_ex", 32'(bus.stall_ex), 32'd0);
        chk("flush_div hilo_we", 32'(bus.hilo_we), 32'd0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("flush_div busy", 32'(bus.busy), 32'd0);
        chk("flush_div hi kept", bus.hi_out, last_hi);
        chk("flush_div lo kept", bus.lo_out, last_lo);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.hilo_we || bus.busy) extra++;
        end
        chk("flush_div quiet", 32'(extra), 32'd0);
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 2, "post_flush multu");
        go_idle();

        // Flush landing in DONE suppresses the strobe.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = 2'b00;
        bus.src_a    = 32'd3;
        bus.src_b    = 32'd4;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_done hilo_we", 32'(bus.hilo_we), 32'd0);
        chk("flush_done stall_ex", 32'(bus.stall_ex), 32'd0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("flush_done busy", 32'(bus.busy), 32'd0);

        // Reset mid-multiply clears everything, then back-to-back MULT and DIVU.
        issue(2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1, "pre_rst divz");
        @(negedge clk);
        bus.op    = 2'b00;
        bus.src_a = 32'd5;
        bus.src_b = 32'd5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("rst_mid hi", bus.hi_out, 32'd0);
        chk("rst_mid lo", bus.lo_out, 32'd0);
        chk("rst_mid div_zero", 32'(bus.div_zero), 32'd0);
        chk("rst_mid busy", 32'(bus.busy), 32'd0);
        chk("rst_mid hilo_we", 32'(bus.hilo_we), 32'd0);
        issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2, "b2b mult");
        issue(2'b11, 32'd7, 32'd7, 32'd0, 32'd1, 1'b0, 33, "b2b divu");
        go_idle();

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, edz, elat);
            issue(rop, ra, rb, ehi, elo, edz, elat, $sformatf("rand%0d op%0d", i, rop));
            if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
